fb_read_scheduler: RTL and testbench

Round-robin burst scheduler that shares the framebuffer SRAM read port among several requesters, such as the UART readback path and the image-processing engines. Each requester asks for a burst of consecutive 32-bit words. The scheduler owns the SRAM `rd_en`/`rd_addr` signals and streams `rd_data` back to the burst owner with a fixed latency. It also snoops the SRAM write port so it can optionally forward same-cycle writes.

---
 rtl/fb_sched_pkg.sv | 28 ++
 rtl/fb_read_scheduler_arb.sv | 49 ++++
 rtl/fb_read_scheduler.sv | 144 ++++++++++++++
 tb/tb_fb_read_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared types and default sizes for the framebuffer read scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_sched_pkg;

  // Default geometry of the framebuffer SRAM and burst descriptor.
  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 32;
  localparam int FB_LEN_W  = 8;
  // Requester id field in the response stage; covers up to 8 requesters.
  localparam int FB_ID_W   = 3;

  // Issue FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // One-deep response stage that rides alongside the SRAM read latency.
  typedef struct packed {
    logic                 valid;
    logic [FB_ID_W-1:0]   id;
    logic                 last;
    logic                 byp;
    logic [FB_DATA_W-1:0] byp_data;
  } rsp_stage_t;

endpackage

// File: rtl/fb_read_scheduler_arb.sv
// Round-robin picker: lowest-latency one-hot choice starting after the last winner.
// Latency: combinational grant; pointer advances on the clock edge of a taken grant.
// Backpressure: pointer only moves when the caller accepts the grant (adv high).
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_any
);

  // Index of the most recently granted requester; search starts just after it.
  logic [IDX_W-1:0] last_q;

  // Scan requesters in rotated order and take the first one asserting.
  always_comb begin
    int               k;
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    k       = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k   = (int'(last_q) + 1 + i) % NUM_REQ;
      idx = IDX_W'(k);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  // Reset makes requester 0 the first in line; otherwise follow the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (adv && gnt_any) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/fb_read_scheduler.sv
// Round-robin burst scheduler owning the framebuffer SRAM read port.
// Latency: grant at T, reads issued T+1..T+1+len, responses T+2..T+2+len.
// Backpressure: requests wait while a burst issues; responses cannot be stalled.
// Build option FB_READ_SCHED_WR_BYPASS_EN forwards same-cycle snooped writes.
module fb_read_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W,
  parameter int LEN_W   = FB_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      busy,
  output logic                      sram_rd_en,
  output logic [ADDR_W-1:0]         sram_rd_addr,
  input  logic [DATA_W-1:0]         sram_rd_data,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t             st;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [ID_W-1:0]    id_q;
  logic               rd_last;
  rsp_stage_t         rsp_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               arb_adv;

  // Only arbitrate while no burst is being issued, so there is no preemption.
  assign arb_adv = (st == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .adv     (arb_adv),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Issue FSM: IDLE latches the winner's descriptor, BURST emits one read per
  // cycle. The state flips back to IDLE on the edge that issues the final word,
  // so a new grant can land the cycle after the last read (one dead issue slot).
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      req_ready    <= '0;
      busy         <= 1'b0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      rd_last      <= 1'b0;
    end else begin
      req_ready  <= '0;
      busy       <= 1'b0;
      sram_rd_en <= 1'b0;
      rd_last    <= 1'b0;
      case (st)
        IDLE: begin
          if (gnt_any) begin
            req_ready <= gnt;
            addr_q    <= req_addr[gnt_id*ADDR_W +: ADDR_W];
            cnt_q     <= req_len[gnt_id*LEN_W +: LEN_W];
            id_q      <= gnt_id;
            st        <= BURST;
          end
        end
        BURST: begin
          sram_rd_en   <= 1'b1;
          busy         <= 1'b1;
          sram_rd_addr <= addr_q;
          // Natural truncation gives the modulo-2^ADDR_W wrap.
          addr_q       <= addr_q + 1'b1;
          rd_last      <= (cnt_q == '0);
          if (cnt_q == '0) begin
            st <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Response stage: follows each issued read by one cycle, matching SRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= sram_rd_en;
      rsp_q.id    <= FB_ID_W'(id_q);
      rsp_q.last  <= sram_rd_en & rd_last;
`ifdef FB_READ_SCHED_WR_BYPASS_EN
      // A write to the word being read this cycle wins over the stale SRAM data.
      rsp_q.byp      <= sram_rd_en && wr_en && (wr_addr == sram_rd_addr);
      rsp_q.byp_data <= FB_DATA_W'(wr_data);
`else
      rsp_q.byp      <= 1'b0;
      rsp_q.byp_data <= '0;
`endif
    end
  end

`ifndef FB_READ_SCHED_WR_BYPASS_EN
  // Snoop port is not consumed in this build.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // Steer the shared data bus; zero whenever no word is being returned.
  always_comb begin
    rsp_data  = '0;
    rsp_valid = '0;
    rsp_last  = 1'b0;
    if (rsp_q.valid) begin
      rsp_valid = NUM_REQ'(1) << rsp_q.id;
      rsp_last  = rsp_q.last;
      rsp_data  = rsp_q.byp ? DATA_W'(rsp_q.byp_data) : sram_rd_data;
    end
  end

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Scoreboard bench for fb_read_scheduler with a behavioural 1-cycle SRAM.
module tb_fb_read_scheduler;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*LW-1:0] req_len   = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            busy;
  logic            sram_rd_en;
  logic [AW-1:0]   sram_rd_addr;
  logic [DW-1:0]   sram_rd_data = '0;
  logic            wr_en   = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;

  fb_read_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // SRAM model: read-before-write on the same edge, one-cycle read latency.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; logic [DW-1:0] data; logic last; int off; } rsp_e;
  typedef struct { int id; logic [AW-1:0] addr; int off; } rd_e;
  typedef struct { int id; int gap; } gnt_e;

  rsp_e rsp_exp[$];
  rd_e  rd_exp[$];
  gnt_e gnt_exp[$];

  int gnt_cyc [N];
  int prev_gnt = 0;
  int rsp_cnt [N];

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: responses, then read issues, then grants, all sampled mid-cycle.
  always @(negedge clk) begin
    rsp_e r; rd_e d; gnt_e g; int id;
    if (rsp_valid != '0) begin
      id = onehot_idx(rsp_valid);
      chk("rsp_onehot", $onehot(rsp_valid), 1);
      if (rsp_exp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        r = rsp_exp.pop_front();
        chk("rsp_id", id, r.id);
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_last", rsp_last, r.last);
        chk("rsp_latency", cyc - gnt_cyc[r.id], r.off);
      end
      if (id >= 0) rsp_cnt[id]++;
    end else if (rsp_last || rsp_data != '0) begin
      chk("rsp_idle_quiet", {rsp_last, rsp_data}, 0);
    end
    if (sram_rd_en || busy) chk("busy_vs_issue", busy, sram_rd_en);
    if (sram_rd_en) begin
      if (rd_exp.size() == 0) chk("rd_unexpected", sram_rd_addr, 0);
      else begin
        d = rd_exp.pop_front();
        chk("rd_addr", sram_rd_addr, d.addr);
        chk("rd_latency", cyc - gnt_cyc[d.id], d.off);
      end
    end
    if (req_ready != '0) begin
      id = onehot_idx(req_ready);
      chk("gnt_onehot", $onehot(req_ready), 1);
      if (gnt_exp.size() == 0) chk("gnt_unexpected", req_ready, 0);
      else begin
        g = gnt_exp.pop_front();
        chk("gnt_id", id, g.id);
        if (g.gap >= 0) chk("gnt_gap", cyc - prev_gnt, g.gap);
      end
      if (id >= 0) gnt_cyc[id] = cyc;
      prev_gnt = cyc;
    end
  end

  // Push grant, read-issue and response expectations for one burst.
  task automatic exp_burst(input int id, input logic [AW-1:0] a, input int len,
                           input int gap, input int nrd, input int nrsp);
    logic [AW-1:0] x;
    gnt_exp.push_back('{id, gap});
    for (int k = 0; k < nrd; k++) begin
      x = a + AW'(k);
      rd_exp.push_back('{id, x, 1 + k});
    end
    for (int k = 0; k < nrsp; k++) begin
      x = a + AW'(k);
      rsp_exp.push_back('{id, mem[x], (k == len), 2 + k});
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[id*AW +: AW] = a;
    req_len[id*LW +: LW]  = l;
    req_valid[id]         = 1'b1;
  endtask

  // Wait (bounded) until the given requester is granted; leaves us in grant cycle.
  task automatic wait_gnt(input int id);
    bit seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      tick();
      if (req_ready[id]) seen = 1;
    end
    chk("grant_seen", seen, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_last"}, rsp_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_en"}, sram_rd_en, 0);
    chk({tag, "_rd_addr"}, sram_rd_addr, 0);
  endtask

  initial begin
    int cnt, base1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    mem[14'h0020] = 32'h1111_1111;
    for (int i = 0; i < N; i++) begin gnt_cyc[i] = 0; rsp_cnt[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst = 1'b0;

    // Fairness: three len-0 requesters, grants 0,1,2,0,1,2 every 2 cycles
    exp_burst(0, 14'h0200, 0, -1, 1, 1);
    exp_burst(1, 14'h0300, 0, 2, 1, 1);
    exp_burst(2, 14'h0400, 0, 2, 1, 1);
    exp_burst(0, 14'h0200, 0, 2, 1, 1);
    exp_burst(1, 14'h0300, 0, 2, 1, 1);
    exp_burst(2, 14'h0400, 0, 2, 1, 1);
    set_req(0, 14'h0200, 0);
    set_req(1, 14'h0300, 0);
    set_req(2, 14'h0400, 0);
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 6; n++) begin
      tick();
      if (req_ready != '0) cnt++;
    end
    req_valid = '0;
    chk("fair_grants", cnt, 6);
    repeat (6) tick();

    // Single burst: requester 1, 0x0100, len 3
    exp_burst(1, 14'h0100, 3, -1, 4, 4);
    set_req(1, 14'h0100, 8'd3);
    wait_gnt(1);
    req_valid[1] = 1'b0;
    repeat (8) tick();

    // Address wrap: 0x3FFE, len 3
    exp_burst(0, 14'h3FFE, 3, -1, 4, 4);
    set_req(0, 14'h3FFE, 8'd3);
    wait_gnt(0);
    req_valid[0] = 1'b0;
    repeat (8) tick();

    // Collision: write 0xDEADBEEF to 0x0020 on the issue cycle
    gnt_exp.push_back('{0, -1});
    rd_exp.push_back('{0, 14'h0020, 1});
`ifdef FB_READ_SCHED_WR_BYPASS_EN
    rsp_exp.push_back('{0, 32'hDEAD_BEEF, 1'b1, 2});
`else
    rsp_exp.push_back('{0, 32'h1111_1111, 1'b1, 2});
`endif
    set_req(0, 14'h0020, 8'd0);
    wait_gnt(0);
    req_valid[0] = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 14'h0020; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    repeat (4) tick();

    // Max burst (256 words) with requester 2 withdrawing mid-burst
    exp_burst(1, 14'h1000, 255, -1, 256, 256);
    base1 = rsp_cnt[1];
    set_req(1, 14'h1000, 8'hFF);
    wait_gnt(1);
    req_valid[1] = 1'b0;
    repeat (50) tick();
    set_req(2, 14'h2000, 8'd0);
    repeat (100) tick();
    req_valid[2] = 1'b0;
    repeat (130) tick();
    chk("max_burst_pulses", rsp_cnt[1] - base1, 256);

    // Mid-burst reset at issue 10, then requester 0 beats requester 2
    exp_burst(2, 14'h0500, 255, -1, 10, 9);
    set_req(2, 14'h0500, 8'hFF);
    wait_gnt(2);
    req_valid[2] = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    set_req(0, 14'h0600, 8'd0);
    set_req(2, 14'h0700, 8'd0);
    @(posedge clk); @(negedge clk);
    chk("midrst_rd_en", sram_rd_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    tick();
    exp_burst(0, 14'h0600, 0, -1, 1, 1);
    exp_burst(2, 14'h0700, 0, 2, 1, 1);
    rst = 1'b0;
    wait_gnt(0);
    req_valid[0] = 1'b0;
    wait_gnt(2);
    req_valid[2] = 1'b0;
    repeat (10) tick();

    chk("gnt_queue_left", gnt_exp.size(), 0);
    chk("rd_queue_left", rd_exp.size(), 0);
    chk("rsp_queue_left", rsp_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always reaches a summary line.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
